// File: rtl/mdc_pkg.sv
// ---------------------------------------------------------------------------
// mdc_pkg
//   Shared definitions for the mult_div_ctrl sequencer: FSM state encoding,
//   the operation code seen on the `op` pin, and the default RUN budgets.
// ---------------------------------------------------------------------------
package mdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic OP_MULT = 1'b1;
    localparam logic OP_DIV  = 1'b0;

    // Default RUN budgets; each must cover the unit's latency after clear.
    localparam int MULT_CYCLES_DEF = 33;
    localparam int DIV_CYCLES_DEF  = 34;
    localparam int CNT_W_DEF       = 6;

endpackage

// File: rtl/mdc_hilo.sv
// ---------------------------------------------------------------------------
// mdc_hilo
//   Architectural HI/LO registers. Loads the unit result on capture (with the
//   MIPS DIV swap: quotient -> LO, remainder -> HI) and services MTHI/MTLO.
//   MTHI/MTLO take priority over a capture in the same cycle.
// Ports
//   clk, reset      clock, synchronous active-high reset
//   capture_i       load HI/LO from the unit this cycle
//   op_i            operation being captured (OP_MULT / OP_DIV)
//   md_high_i       unit high word (mult: product[63:32]; div: quotient)
//   md_low_i        unit low word  (mult: product[31:0];  div: remainder)
//   wr_en_i         MTHI/MTLO strobes are allowed (sequencer not busy)
//   hi_wr_i/lo_wr_i MTHI / MTLO strobes
//   wr_data_i       MTHI/MTLO data
//   hi_o, lo_o      HI and LO register contents
// ---------------------------------------------------------------------------
module mdc_hilo
    import mdc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        capture_i,
    input  logic        op_i,
    input  logic [31:0] md_high_i,
    input  logic [31:0] md_low_i,
    input  logic        wr_en_i,
    input  logic        hi_wr_i,
    input  logic        lo_wr_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        hi_d = hi_q;
        lo_d = lo_q;

        if (capture_i) begin
            if (op_i == OP_MULT) begin
                hi_d = md_high_i;
                lo_d = md_low_i;
            end else begin
                // DIV: quotient goes to LO, remainder to HI.
                hi_d = md_low_i;
                lo_d = md_high_i;
            end
        end

        if (wr_en_i && hi_wr_i) hi_d = wr_data_i;
        if (wr_en_i && lo_wr_i) lo_d = wr_data_i;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/mult_div_ctrl.sv
// ---------------------------------------------------------------------------
// mult_div_ctrl
//   Sequencer for the iterative mult_div unit. Latches MULT/DIV operands,
//   clears the unit, lets it run for a fixed cycle budget, captures the result
//   into HI/LO and pulses done. Also services MTHI/MTLO while idle.
//   FSM: IDLE -> CLEAR -> RUN (N cycles) -> CAPTURE -> DONE -> IDLE/CLEAR.
//
// Build option
//   MDC_DIVZERO_TRAP_EN : when defined, a DIV whose unit flags divide-by-zero
//                         at CAPTURE pulses div_zero_exc with done and leaves
//                         HI/LO untouched. Otherwise div_zero_exc is 0 and
//                         HI/LO load from the unit as for any DIV.
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start, op         request (op 1 = MULT, 0 = DIV), sampled in IDLE/DONE
//   a_in, b_in        operands, sampled with start
//   hi_wr, lo_wr      MTHI / MTLO strobes (dropped while busy)
//   wr_data           MTHI/MTLO data
//   busy              high in CLEAR, RUN, CAPTURE
//   done              one-cycle pulse in DONE
//   div_zero_exc      divide-by-zero pulse with done (trap build only)
//   hi_out, lo_out    HI / LO registers
//   md_ctrl           unit mode select (latched op while busy)
//   md_reset          unit clear (CLEAR only)
//   md_div_load       unit divide load (~op while busy)
//   md_a, md_b        latched operands to unit
//   md_high, md_low   unit result words
//   md_div_zero       unit divide-by-zero flag
// ---------------------------------------------------------------------------
module mult_div_ctrl
    import mdc_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        md_ctrl,
    output logic        md_reset,
    output logic        md_div_load,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic [31:0] md_high,
    input  logic [31:0] md_low,
    input  logic        md_div_zero
);

`ifdef MDC_DIVZERO_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic               op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dz_q, dz_d;
    logic               capture;
    logic               hilo_capture;

    // Next-state logic and operand/counter updates.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        capture = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new request exactly like IDLE.
                state_d = ST_IDLE;
                if (start) begin
                    op_d    = op;
                    a_d     = a_in;
                    b_d     = b_in;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // Load N-1 so RUN lasts exactly N cycles including the zero.
                cnt_d   = (op_q == OP_MULT) ? CNT_W'(MULT_CYCLES - 1)
                                            : CNT_W'(DIV_CYCLES - 1);
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                dz_d    = (op_q == OP_DIV) && md_div_zero;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    // Outputs are decoded from registered state only.
    assign busy         = (state_q == ST_CLEAR) || (state_q == ST_RUN) ||
                          (state_q == ST_CAPTURE);
    assign done         = (state_q == ST_DONE);
    assign md_reset     = (state_q == ST_CLEAR);
    assign md_ctrl      = busy & op_q;
    assign md_div_load  = busy & ~op_q;
    assign md_a         = a_q;
    assign md_b         = b_q;
    assign div_zero_exc = TRAP_EN & done & dz_q;

    // In the trap build a flagged divide leaves HI/LO untouched.
    assign hilo_capture = capture &
                          ~(TRAP_EN & (op_q == OP_DIV) & md_div_zero);

    mdc_hilo u_hilo (
        .clk       (clk),
        .reset     (reset),
        .capture_i (hilo_capture),
        .op_i      (op_q),
        .md_high_i (md_high),
        .md_low_i  (md_low),
        .wr_en_i   (~busy),
        .hi_wr_i   (hi_wr),
        .lo_wr_i   (lo_wr),
        .wr_data_i (wr_data),
        .hi_o      (hi_out),
        .lo_o      (lo_out)
    );

endmodule

// File: tb/tb_mult_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_div_ctrl
//   Drives mult_div_ctrl with directed and random traffic. A small model of
//   the iterative unit answers md_a/md_b (garbage until its latency has
//   elapsed after md_reset). A transaction-level reference tracks each
//   accepted request as an elapsed-cycle offset and predicts every output.
// ---------------------------------------------------------------------------
module tb_mult_div_ctrl;

    localparam int N_MULT = 33;
    localparam int N_DIV  = 34;

`ifdef MDC_DIVZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, op, hi_wr, lo_wr;
    logic [31:0] a_in, b_in, wr_data;
    logic        busy, done, div_zero_exc, md_ctrl, md_reset, md_div_load;
    logic [31:0] hi_out, lo_out, md_a, md_b, md_high, md_low;
    logic        md_div_zero;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mult_div_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .a_in         (a_in),
        .b_in         (b_in),
        .hi_wr        (hi_wr),
        .lo_wr        (lo_wr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .div_zero_exc (div_zero_exc),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .md_ctrl      (md_ctrl),
        .md_reset     (md_reset),
        .md_div_load  (md_div_load),
        .md_a         (md_a),
        .md_b         (md_b),
        .md_high      (md_high),
        .md_low       (md_low),
        .md_div_zero  (md_div_zero)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Unit result: {high, low}. MULT: signed 64-bit product.
    // DIV: {quotient, remainder}, truncating toward zero.
    function automatic logic [63:0] unit_calc(input logic o,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint p;
        int     q, r;
        if (o) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
        end
        if (b == 32'h0) return {32'hFFFF_FFFF, a};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {q, r};
    endfunction

    // ---------------- iterative unit model ----------------
    int          ucnt = 0;
    logic [31:0] g_hi, g_lo;
    logic [63:0] u_res;
    int          u_lat;

    always @(posedge clk) begin
        if (md_reset) ucnt <= 0;
        else if (ucnt < 1000) ucnt <= ucnt + 1;
        g_hi <= $urandom;
        g_lo <= $urandom;
    end

    assign u_res       = unit_calc(md_ctrl, md_a, md_b);
    assign u_lat       = md_ctrl ? N_MULT : N_DIV;
    assign md_high     = (ucnt >= u_lat) ? u_res[63:32] : g_hi;
    assign md_low      = (ucnt >= u_lat) ? u_res[31:0]  : g_lo;
    assign md_div_zero = !md_ctrl && (md_b == 32'h0);

    // ---------------- transaction-level reference ----------------
    // m_k counts cycles since the accepting edge: 0 = clear, 1..N = run,
    // N+1 = capture, N+2 = done.
    bit          m_active = 1'b0;
    int          m_k = 0, m_n = 0;
    logic        m_op = 1'b0, m_dz = 1'b0;
    logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;

    always @(posedge clk) begin : model
        bit          busy_now;
        logic [63:0] r;
        if (reset) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_op     <= 1'b0;
            m_a      <= '0;
            m_b      <= '0;
            m_hi     <= '0;
            m_lo     <= '0;
            m_dz     <= 1'b0;
        end else begin
            busy_now = m_active && (m_k <= m_n + 1);
            if (m_active && m_k == m_n + 1) begin
                r = unit_calc(m_op, m_a, m_b);
                m_dz <= (m_op == 1'b0) && (m_b == 32'h0);
                if (!(TRAP && m_op == 1'b0 && m_b == 32'h0)) begin
                    if (m_op) begin
                        m_hi <= r[63:32];
                        m_lo <= r[31:0];
                    end else begin
                        m_lo <= r[63:32];
                        m_hi <= r[31:0];
                    end
                end
            end
            if (!busy_now && hi_wr) m_hi <= wr_data;
            if (!busy_now && lo_wr) m_lo <= wr_data;
            if (start && !busy_now) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_op     <= op;
                m_a      <= a_in;
                m_b      <= b_in;
                m_n      <= op ? N_MULT : N_DIV;
            end else if (m_active) begin
                if (m_k >= m_n + 2) m_active <= 1'b0;
                else m_k <= m_k + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic e_busy, e_done;
        if (chk_en) begin
            e_busy = m_active && (m_k <= m_n + 1);
            e_done = m_active && (m_k == m_n + 2);
            check("busy",         {31'b0, busy},         {31'b0, e_busy});
            check("done",         {31'b0, done},         {31'b0, e_done});
            check("md_reset",     {31'b0, md_reset},     {31'b0, m_active && m_k == 0});
            check("md_ctrl",      {31'b0, md_ctrl},      {31'b0, e_busy & m_op});
            check("md_div_load",  {31'b0, md_div_load},  {31'b0, e_busy & ~m_op});
            check("div_zero_exc", {31'b0, div_zero_exc}, {31'b0, TRAP & e_done & m_dz});
            check("md_a",   md_a,   m_a);
            check("md_b",   md_b,   m_b);
            check("hi_out", hi_out, m_hi);
            check("lo_out", lo_out, m_lo);
        end
    end

    // Issue a request at the current negedge and wait for done.
    // lat counts negedges after the accepting edge (1 = CLEAR cycle).
    task automatic run_op(input logic o, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        lat   = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            hi_wr = 1'b0;
            lo_wr = 1'b0;
            lat++;
        end while (done !== 1'b1 && lat < 200);
        if (lat >= 200) check("done_timeout", 32'd0, 32'd1);
    endtask

    int  lat;
    bit  seen_done;

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);

        // 1: MULT 7 * -3
        run_op(1'b1, 32'd7, 32'hFFFF_FFFD, lat);
        check("t1_latency", lat, N_MULT + 3);
        check("t1_hi", hi_out, 32'hFFFF_FFFF);
        check("t1_lo", lo_out, 32'hFFFF_FFEB);
        @(negedge clk);
        check("t1_busy_after", {31'b0, busy}, 32'd0);

        // 2: DIV -17 / 5
        run_op(1'b0, 32'hFFFF_FFEF, 32'd5, lat);
        check("t2_latency", lat, N_DIV + 3);
        check("t2_lo", lo_out, 32'hFFFF_FFFD);
        check("t2_hi", hi_out, 32'hFFFF_FFFE);
        @(negedge clk);

        // 3: DIV 100 / 0
        run_op(1'b0, 32'd100, 32'd0, lat);
        if (TRAP) begin
            check("t3_exc", {31'b0, div_zero_exc}, 32'd1);
            check("t3_hi",  hi_out, 32'hFFFF_FFFE);
            check("t3_lo",  lo_out, 32'hFFFF_FFFD);
        end else begin
            check("t3_exc", {31'b0, div_zero_exc}, 32'd0);
            check("t3_hi",  hi_out, 32'd100);
            check("t3_lo",  lo_out, 32'hFFFF_FFFF);
        end
        @(negedge clk);

        // 4: reset mid-RUN aborts the operation
        start = 1'b1; op = 1'b1; a_in = 32'd5; b_in = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_busy", {31'b0, busy}, 32'd0);
        check("t4_hi", hi_out, 32'h0);
        check("t4_lo", lo_out, 32'h0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("t4_no_done", {31'b0, seen_done}, 32'd0);
        run_op(1'b1, 32'd2, 32'd3, lat);
        check("t4_lo", lo_out, 32'd6);
        check("t4_hi2", hi_out, 32'd0);
        @(negedge clk);

        // 5: start and MTHI while busy are dropped
        start = 1'b1; op = 1'b1; a_in = 32'd1000; b_in = 32'd1000;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start   = (lat == 5);
            hi_wr   = (lat == 5);
            op      = (lat == 5) ? 1'b0 : 1'b1;
            a_in    = (lat == 5) ? 32'd1 : 32'd1000;
            b_in    = (lat == 5) ? 32'd1 : 32'd1000;
            wr_data = 32'hDEAD_BEEF;
        end while (done !== 1'b1 && lat < 200);
        start = 1'b0; hi_wr = 1'b0;
        check("t5_latency", lat, N_MULT + 3);
        check("t5_hi", hi_out, 32'h0);
        check("t5_lo", lo_out, 32'h000F_4240);
        @(negedge clk);
        hi_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_wr = 1'b0;
        check("t5_mthi", hi_out, 32'hDEAD_BEEF);
        check("t5_lo_kept", lo_out, 32'h000F_4240);

        // 6: back-to-back from DONE, with MTLO in the same DONE cycle
        run_op(1'b1, 32'd5, 32'd5, lat);
        check("t6_first_lo", lo_out, 32'd25);
        lo_wr = 1'b1; wr_data = 32'hCAFE_F00D;
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("t6_latency", lat, N_MULT + 3);
        check("t6_hi", hi_out, 32'h0);
        check("t6_lo", lo_out, 32'h1);
        @(negedge clk);

        // Both strobes together in IDLE
        hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h1234_5678;
        @(negedge clk);
        hi_wr = 1'b0; lo_wr = 1'b0;
        check("both_hi", hi_out, 32'h1234_5678);
        check("both_lo", lo_out, 32'h1234_5678);

        // Random traffic against the reference
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset   = ($urandom_range(0, 599) == 0);
            start   = ($urandom_range(0, 5) == 0);
            op      = 1'($urandom);
            a_in    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom;
            b_in    = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            hi_wr   = ($urandom_range(0, 9) == 0);
            lo_wr   = ($urandom_range(0, 9) == 0);
            wr_data = $urandom;
        end
        reset = 1'b0; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        repeat (50) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
